// File: rtl/pipe_register.sv
// Elastic pipeline register: STAGES valid/ready stages of N bits with global enable,
// synchronous flush and a registered occupancy count. Empty stages accept even when downstream stalls.
module pipe_register #(
    parameter int            N        = 32,
    parameter int            STAGES   = 2,
    parameter logic [N-1:0]  RSTVALUE = '0,
    localparam int           CW       = ($clog2(STAGES + 1) > 1) ? $clog2(STAGES + 1) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          flush,
    input  logic [N-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [N-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] count
);

    // Handshake: a word moves in on in_valid & in_ready and out on out_valid & out_ready.
    // No transfer of any kind happens while ena=0; flush drops all words and blocks input.

    logic [STAGES-1:0] v_q, v_d;
    logic [N-1:0]      d_q [STAGES];
    logic [N-1:0]      d_d [STAGES];
    logic [CW-1:0]     count_q, count_d;

    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] up_v;
    logic [N-1:0]      up_d [STAGES];
    logic              r_acc;

    // A stage may advance if it is empty or anything downstream of it can move.
    always_comb begin
        r_acc = out_ready | ~v_q[STAGES-1];
        rdy   = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            r_acc  = r_acc | ~v_q[i];
            rdy[i] = r_acc;
        end
    end

    always_comb begin
        up_v[0] = in_valid;
        up_d[0] = in_data;
        for (int i = 1; i < STAGES; i++) begin
            up_v[i] = v_q[i-1];
            up_d[i] = d_q[i-1];
        end
    end

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (ena) begin
            if (flush) begin
                v_d = '0;
            end else begin
                for (int i = 0; i < STAGES; i++) begin
                    if (rdy[i]) begin
                        v_d[i] = up_v[i];
                        // Bubbles never overwrite data, so out_data keeps the last real word.
                        if (up_v[i]) d_d[i] = up_d[i];
                    end
                end
            end
        end
        count_d = '0;
        for (int i = 0; i < STAGES; i++) begin
            count_d = count_d + CW'(v_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q     <= '0;
            count_q <= '0;
            for (int i = 0; i < STAGES; i++) d_q[i] <= RSTVALUE;
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
            d_q     <= d_d;
        end
    end

    assign in_ready  = rdy[0] & ena & ~flush;
    assign out_data  = d_q[STAGES-1];
    assign out_valid = v_q[STAGES-1];
    assign count     = count_q;

endmodule

// File: tb/tb_pipe_register.sv
// Bench for pipe_register (N=16, STAGES=3): directed vector table, reset-mid-stream sequences,
// and randomized traffic checked against an in-order queue model of words in flight.
module tb_pipe_register;

    localparam int            N        = 16;
    localparam int            STAGES   = 3;
    localparam logic [N-1:0]  RSTVALUE = 16'hA5A5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ena = 1'b1;
    logic         flush = 1'b0;
    logic [N-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [1:0]   count;

    int total = 0;
    int bad   = 0;

    logic [N-1:0] exp_q[$];

    typedef struct {
        logic         pre_rst;
        logic         ena;
        logic         flush;
        logic         iv;
        logic [N-1:0] din;
        logic         ordy;
        logic         e_ir;
        logic         e_ov;
        logic [N-1:0] e_od;
        int           e_cnt;
    } vec_t;

    vec_t vecs[$];

    pipe_register #(.N(N), .STAGES(STAGES), .RSTVALUE(RSTVALUE)) dut (
        .clk(clk), .rst(rst), .ena(ena), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic add(input logic pr, input logic en, input logic fl, input logic iv,
                       input logic [N-1:0] din, input logic ordy, input logic ir,
                       input logic ov, input logic [N-1:0] od, input int cnt);
        vec_t t;
        t.pre_rst = pr; t.ena = en; t.flush = fl; t.iv = iv; t.din = din; t.ordy = ordy;
        t.e_ir = ir; t.e_ov = ov; t.e_od = od; t.e_cnt = cnt;
        vecs.push_back(t);
    endtask

    // Called at a falling edge; returns at a falling edge with reset released.
    task automatic do_reset();
        rst = 1'b1; ena = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'(RSTVALUE));
        chk("rst_count", 32'(count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
    endtask

    // One randomized/driven cycle checked against the queue model; starts and ends at a falling edge.
    task automatic model_cycle(input logic en, input logic fl, input logic iv, input logic ordy);
        logic exp_ir;
        ena = en; flush = fl; in_valid = iv; out_ready = ordy; in_data = N'($urandom);
        #1;
        exp_ir = en && !fl && (exp_q.size() < STAGES || ordy);
        chk("rnd_in_ready", 32'(in_ready), 32'(exp_ir));
        chk("rnd_count", 32'(count), 32'(exp_q.size()));
        if (en && !fl && out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL rnd_pop: got %0h want none (model empty)", out_data);
            end else begin
                chk("rnd_out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
        if (iv && exp_ir) exp_q.push_back(in_data);
        if (en && fl) exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        // Streaming: first word after 3 edges, then one per cycle, count holds at 3.
        add(1, 1,0,1,16'h0001,1, 1,0,RSTVALUE,1);
        add(0, 1,0,1,16'h0002,1, 1,0,RSTVALUE,2);
        add(0, 1,0,1,16'h0003,1, 1,1,16'h0001,3);
        for (int k = 4; k <= 8; k++) add(0, 1,0,1,N'(k),1, 1,1,N'(k-2),3);
        add(0, 1,0,0,16'h0000,1, 1,1,16'h0007,2);
        add(0, 1,0,0,16'h0000,1, 1,1,16'h0008,1);
        add(0, 1,0,0,16'h0000,1, 1,0,16'h0008,0);
        // Backpressure: full at 3, push and pop on the same edge keeps count at 3.
        add(1, 1,0,1,16'h0010,0, 1,0,RSTVALUE,1);
        add(0, 1,0,1,16'h0011,0, 1,0,RSTVALUE,2);
        add(0, 1,0,1,16'h0012,0, 1,1,16'h0010,3);
        add(0, 1,0,1,16'h0013,0, 0,1,16'h0010,3);
        add(0, 1,0,1,16'h0013,0, 0,1,16'h0010,3);
        add(0, 1,0,1,16'h0013,1, 1,1,16'h0011,3);
        add(0, 1,0,0,16'h0000,0, 0,1,16'h0011,3);
        add(0, 1,0,0,16'h0000,1, 1,1,16'h0012,2);
        add(0, 1,0,0,16'h0000,1, 1,1,16'h0013,1);
        add(0, 1,0,0,16'h0000,1, 1,0,16'h0013,0);
        // Bubble collapse under stall, order preserved on release.
        add(1, 1,0,1,16'h0020,0, 1,0,RSTVALUE,1);
        add(0, 1,0,0,16'h0000,0, 1,0,RSTVALUE,1);
        add(0, 1,0,0,16'h0000,0, 1,1,16'h0020,1);
        add(0, 1,0,1,16'h0021,0, 1,1,16'h0020,2);
        add(0, 1,0,0,16'h0000,0, 1,1,16'h0020,2);
        add(0, 1,0,0,16'h0000,1, 1,1,16'h0021,1);
        add(0, 1,0,0,16'h0000,1, 1,0,16'h0021,0);
        // Flush: drops everything, blocks 0x33, data registers keep their contents.
        add(1, 1,0,1,16'h0030,0, 1,0,RSTVALUE,1);
        add(0, 1,0,1,16'h0031,0, 1,0,RSTVALUE,2);
        add(0, 1,0,1,16'h0032,0, 1,1,16'h0030,3);
        add(0, 1,1,1,16'h0033,1, 0,0,16'h0030,0);
        add(0, 1,0,0,16'h0000,1, 1,0,16'h0030,0);
        // Enable low freezes state even with out_ready and in_valid high.
        add(1, 1,0,1,16'h0040,0, 1,0,RSTVALUE,1);
        add(0, 1,0,1,16'h0041,0, 1,0,RSTVALUE,2);
        add(0, 1,0,0,16'h0000,0, 1,1,16'h0040,2);
        for (int k = 0; k < 4; k++) add(0, 0,0,1,16'h0042,1, 0,1,16'h0040,2);
        add(0, 1,0,0,16'h0000,1, 1,1,16'h0041,1);
        add(0, 1,0,0,16'h0000,1, 1,0,16'h0041,0);
        // flush while ena=0 does nothing.
        add(1, 1,0,1,16'h0050,0, 1,0,RSTVALUE,1);
        add(0, 0,1,0,16'h0000,0, 0,0,RSTVALUE,1);
        add(0, 1,0,0,16'h0000,0, 1,0,RSTVALUE,1);
        add(0, 1,0,0,16'h0000,0, 1,1,16'h0050,1);

        @(negedge clk);
        do_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].pre_rst) do_reset();
            ena = vecs[i].ena; flush = vecs[i].flush; in_valid = vecs[i].iv;
            in_data = vecs[i].din; out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_od));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
            @(negedge clk);
        end

        // Asynchronous reset after two pushes, then again with a full pipeline.
        for (int pass = 2; pass <= 3; pass++) begin
            do_reset();
            out_ready = 1'b0;
            for (int k = 1; k <= pass; k++) begin
                in_valid = 1'b1; in_data = N'(k);
                @(posedge clk);
                @(negedge clk);
            end
            chk($sformatf("mid%0d_count_before", pass), 32'(count), 32'(pass));
            chk($sformatf("mid%0d_ov_before", pass), 32'(out_valid), 32'(pass == 3));
            @(posedge clk);
            #2;
            rst = 1'b1;
            #1;
            chk($sformatf("mid%0d_out_valid", pass), 32'(out_valid), 32'd0);
            chk($sformatf("mid%0d_out_data", pass), 32'(out_data), 32'(RSTVALUE));
            chk($sformatf("mid%0d_count", pass), 32'(count), 32'd0);
            @(negedge clk);
            rst = 1'b0; in_valid = 1'b0;
            #1;
            chk($sformatf("mid%0d_in_ready", pass), 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("mid%0d_count_after", pass), 32'(count), 32'd0);
            @(negedge clk);
        end

        // Randomized traffic against the in-order queue model, then a full drain.
        do_reset();
        exp_q.delete();
        for (int c = 0; c < 600; c++) begin
            model_cycle($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0,
                        1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);
        end
        for (int c = 0; c < STAGES + 3; c++) model_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        chk("drain_model_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_register.md
Name: pipe_register

Overview:
- Parametrised elastic pipeline register: a chain of STAGES registers of width N with valid/ready handshake, global enable, synchronous flush and occupancy count.
- Successor of the single enable-gated register.
- Sits between FPU datapath stages (operand capture, unpack, normalise, round). Stages can stall independently of upstream, and bubbles collapse.

Parameters:
- N, 32, data width in bits (>=1).
- STAGES, 2, number of register stages (>=1); sets zero-stall latency.
- RSTVALUE, 0, value loaded into every data register on reset; N bits wide.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- ena  input  1  global enable; 0 freezes all state.
- flush  input  1  synchronous flush; invalidates all stages.
- in_data  input  N  upstream data.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  stage 0 can accept this cycle.
- out_data  output  N  data of last stage.
- out_valid  output  1  last stage holds valid data.
- out_ready  input  1  downstream accepts out_data this cycle.
- count  output  max(1,$clog2(STAGES+1))  number of valid stages.

Behaviour:
- Per-stage state:
  - v[i] is the valid bit; d[i] is N bits; i=0 is nearest the input.
  - out_data=d[STAGES-1], out_valid=v[STAGES-1].
- Reset (async, any time, including mid-transfer):
  - all v[i]=0 and all d[i]=RSTVALUE immediately.
  - Hence out_valid=0, out_data=RSTVALUE, count=0.
  - in_ready is high after reset if ena=1 and flush=0.
- Ready chain, combinational:
  - rdy[STAGES-1] = !v[STAGES-1] | out_ready.
  - rdy[i] = !v[i] | rdy[i+1].
  - in_ready = rdy[0] & ena & !flush.
  - The out_ready->in_ready path is combinational through all stages; this is accepted by design.
- Advance (clock edge, ena=1, flush=0), for each stage i with rdy[i]=1:
  - v[i] <= upstream valid, where upstream of stage 0 is in_valid and upstream of stage i>0 is v[i-1].
  - d[i] <= upstream data, only if upstream valid=1; otherwise d[i] holds, so no bubble data is written.
- Stages with rdy[i]=0 hold v and d.
- Bubble collapsing: an empty stage accepts even when downstream is stalled.
- Transfer rules:
  - Input handshake completes when in_valid & in_ready.
  - Output handshake completes when out_valid & out_ready.
  - Upstream may drop in_valid without a completed handshake; no data is lost, because nothing is captured unless in_ready=1.
- Latency and throughput:
  - With out_ready=1 and ena=1, a word accepted at edge k appears on out_data after edge k+STAGES-1, i.e. STAGES cycles after in_valid is sampled.
  - Throughput is 1 word/cycle.
- Full: all v=1 and out_ready=0 -> in_ready=0; contents hold indefinitely.
- Full with out_ready=1: in_ready=1 in the same cycle, so a simultaneous push and pop keeps count at STAGES.
- Empty: out_valid=0; out_ready is ignored.
- ena=0:
  - no v or d changes; in_ready=0.
  - out_valid and out_data still show the current last stage.
  - Downstream must not consider a handshake complete while ena=0. The block does not pop, so the same word is re-presented after ena returns.
- flush=1 with ena=1, at the edge:
  - all v <= 0; d unchanged.
  - in_ready=0 during the flush cycle, so no input is captured.
  - Any simultaneous output handshake is discarded.
- flush=1 with ena=0: no effect.
- rst dominates flush and ena.
- count:
  - registered, equal to popcount of v after each edge.
  - Updated in the same edge as v; reset value 0.
  - Never exceeds STAGES.
- STAGES=1: degenerates to a single register with valid/ready. in_ready = (!v | out_ready) & ena & !flush.

Test Plan:
1. Reset mid-stream: N=16, STAGES=3, RSTVALUE=16'hA5A5. Stream 0x0001..0x0003 and assert rst between edges after 2 pushes -> out_valid=0, out_data=16'hA5A5 and count=0 immediately (before the next edge); in_ready=1 after release.
2. Streaming: N=16, STAGES=3, out_ready=1, ena=1. Push 0x0001..0x0008 back-to-back -> 0x0001 at out_data 3 cycles after first accept, then one word/cycle in order; count stays 3 during the steady state.
3. Backpressure/full: STAGES=3, out_ready=0, push 0x10,0x11,0x12,0x13 -> first three accepted, count=3, in_ready=0 while 0x13 waits. Then out_ready=1 for 1 cycle -> 0x10 popped and 0x13 accepted on the same edge; count remains 3.
4. Bubble collapse: STAGES=3, out_ready=0. Push 0x20, idle 2 cycles, push 0x21 -> both accepted, count=2, and the order 0x20 then 0x21 is preserved on release.
5. Flush: pipeline holding 0x30,0x31,0x32 with in_valid=1 (0x33) and flush=1 for one edge -> count=0, out_valid=0 next cycle, 0x33 not captured (in_ready=0 that cycle), out_data keeps its old d value.
6. Enable: with 2 valid words, set ena=0 for 4 cycles while out_ready=1 and in_valid=1 -> count, out_data and v unchanged and in_ready=0; on ena=1, draining resumes starting with the same head word.
